// File: rtl/ifu_fetch_queue_if.sv
// Fetch-queue handshake bundle.
// slave  : seen by the queue (fetch-side push inputs, decoder-side pop outputs, count)
// master : seen by the environment that drives fetch and consumes decode
interface ifu_fetch_queue_if #(
   parameter int unsigned INST_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 3
);
   logic              in_valid_i;
   logic              in_ready_o;
   logic [INST_W-1:0] in_inst_i;
   logic [ADDR_W-1:0] in_addr_i;
   logic              in_err_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [INST_W-1:0] out_inst_o;
   logic [ADDR_W-1:0] out_addr_o;
   logic              out_err_o;
   logic [CNT_W-1:0]  count_o;

   modport slave (
      input  in_valid_i, in_inst_i, in_addr_i, in_err_i, out_ready_i,
      output in_ready_o, out_valid_o, out_inst_o, out_addr_o, out_err_o, count_o
   );

   modport master (
      output in_valid_i, in_inst_i, in_addr_i, in_err_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_inst_o, out_addr_o, out_err_o, count_o
   );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry circular queue of
// {inst, addr, err} with valid/ready on both sides and a synchronous flush.
// Ports: clk, rst (async active-high), flush_i (discard all entries),
//        bus (slave modport): in_* push side, out_* pop side, count_o occupancy.
// Empty queue presents NOP_INST / addr 0 / err 0 with out_valid_o low.
module ifu_fetch_queue #(
   parameter int unsigned      INST_W   = 32,
   parameter int unsigned      ADDR_W   = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   ifu_fetch_queue_if.slave    bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] addr;
      logic              err;
   } entry_t;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               push;
   logic               pop;
   entry_t             head;

   // Handshakes qualify only on registered flags, so no out_ready_i -> in_ready_o path
   always_comb begin
      push        = bus.in_valid_i && in_ready_q && !flush_i;
      pop         = out_valid_q && bus.out_ready_i && !flush_i;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
      in_ready_d  = (count_d != CNT_W'(DEPTH));
      out_valid_d = (count_d != CNT_W'(0));
   end

   // Control state; full/empty flags are kept as flops alongside count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Payload storage is never cleared; pointers and count alone define contents
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= '{inst: bus.in_inst_i, addr: bus.in_addr_i, err: bus.in_err_i};
      end
   end

   assign head = mem[rd_ptr_q];

   // Empty queue shows a NOP bubble instead of stale storage
   assign bus.in_ready_o  = in_ready_q;
   assign bus.out_valid_o = out_valid_q;
   assign bus.out_inst_o  = out_valid_q ? head.inst : NOP_INST;
   assign bus.out_addr_o  = out_valid_q ? head.addr : '0;
   assign bus.out_err_o   = out_valid_q ? head.err  : 1'b0;
   assign bus.count_o     = count_q;
endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
      logic        err;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic saw_200 = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   ent_t sb[$];

   ifu_fetch_queue_if #(.INST_W(32), .ADDR_W(32), .CNT_W(3)) bus ();

   ifu_fetch_queue #(
      .INST_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP_INST(NOP)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (bus.out_valid_o && bus.out_addr_o == 32'h200) saw_200 = 1'b1;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check against the model, update model at posedge
   task automatic cyc(input logic v, input logic [31:0] a, input logic e,
                      input logic r, input logic f);
      logic push_ok, pop_ok;
      ent_t nw;
      @(negedge clk);
      bus.in_valid_i  = v;
      bus.in_addr_i   = a;
      bus.in_inst_i   = inst_of(a);
      bus.in_err_i    = e;
      bus.out_ready_i = r;
      flush           = f;
      #1;
      chk("count", 64'(bus.count_o), 64'(sb.size()));
      chk("in_ready", 64'(bus.in_ready_o), 64'(sb.size() != DEPTH));
      chk("out_valid", 64'(bus.out_valid_o), 64'(sb.size() != 0));
      if (sb.size() == 0) begin
         chk("empty_inst", 64'(bus.out_inst_o), 64'(NOP));
         chk("empty_addr", 64'(bus.out_addr_o), 64'(0));
         chk("empty_err", 64'(bus.out_err_o), 64'(0));
      end else begin
         chk("head_inst", 64'(bus.out_inst_o), 64'(sb[0].inst));
         chk("head_addr", 64'(bus.out_addr_o), 64'(sb[0].addr));
         chk("head_err", 64'(bus.out_err_o), 64'(sb[0].err));
      end
      push_ok = v && (sb.size() < DEPTH) && !f;
      pop_ok  = r && (sb.size() != 0) && !f;
      nw      = '{inst: inst_of(a), addr: a, err: e};
      @(posedge clk);
      if (f) sb.delete();
      else begin
         if (pop_ok)  void'(sb.pop_front());
         if (push_ok) sb.push_back(nw);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      bus.in_valid_i = 1'b0; bus.in_inst_i = '0; bus.in_addr_i = '0;
      bus.in_err_i = 1'b0; bus.out_ready_i = 1'b0;
      #12;
      chk("rst_out_valid", 64'(bus.out_valid_o), 64'(0));
      chk("rst_in_ready", 64'(bus.in_ready_o), 64'(1));
      chk("rst_inst", 64'(bus.out_inst_o), 64'(NOP));
      chk("rst_addr", 64'(bus.out_addr_o), 64'(0));
      chk("rst_count", 64'(bus.count_o), 64'(0));
      @(negedge clk); rst = 1'b0;

      // Reset asserted mid-cycle with 3 entries queued
      cyc(1, 32'h10, 0, 0, 0);
      cyc(1, 32'h14, 0, 0, 0);
      cyc(1, 32'h18, 0, 0, 0);
      @(negedge clk);
      bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(bus.out_valid_o), 64'(0));
      chk("midrst_count", 64'(bus.count_o), 64'(0));
      chk("midrst_inst", 64'(bus.out_inst_o), 64'(NOP));
      chk("midrst_in_ready", 64'(bus.in_ready_o), 64'(1));
      sb.delete();
      @(negedge clk); rst = 1'b0;
      bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;

      // Fill, refuse 5th push, then drain in order
      for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 32'(4 * i), 0, 0, 0);
      #1;
      chk("full_count", 64'(bus.count_o), 64'(4));
      chk("full_in_ready", 64'(bus.in_ready_o), 64'(0));
      cyc(1, 32'h110, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);

      // Full with simultaneous pop: pop taken, push refused
      for (int i = 0; i < 4; i++) cyc(1, 32'h140 + 32'(4 * i), 0, 0, 0);
      cyc(1, 32'h150, 0, 1, 0);
      #1;
      chk("fullpop_count", 64'(bus.count_o), 64'(3));
      chk("fullpop_in_ready", 64'(bus.in_ready_o), 64'(1));
      chk("fullpop_head", 64'(bus.out_addr_o), 64'(32'h144));

      // Flush with count=3, together with a push of 0x200 and a pop
      cyc(1, 32'h200, 0, 1, 1);
      #1;
      chk("flush_count", 64'(bus.count_o), 64'(0));
      chk("flush_out_valid", 64'(bus.out_valid_o), 64'(0));
      cyc(0, 0, 0, 1, 0);

      // Streaming at count=1 with pointer wrap
      cyc(1, 32'h400, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(1, 32'h404 + 32'(4 * i), 0, 1, 0);
         #1;
         chk("stream_count", 64'(bus.count_o), 64'(1));
         chk("stream_lag", 64'(bus.out_addr_o), 64'(32'h404 + 32'(4 * i)));
      end
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);

      // Fault flag carried with its instruction
      cyc(1, 32'h300, 1, 0, 0);
      cyc(1, 32'h304, 0, 0, 0);
      #1;
      chk("err_head_300", 64'(bus.out_err_o), 64'(1));
      cyc(0, 0, 0, 1, 0);
      #1;
      chk("err_head_304_addr", 64'(bus.out_addr_o), 64'(32'h304));
      chk("err_head_304", 64'(bus.out_err_o), 64'(0));
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);

      chk("no_0x200_seen", 64'(saw_200), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ifu_fetch_queue.md
# ifu_fetch_queue

Parametrised instruction buffer between the fetch stage and the decoder. It is the successor to the single-entry IF/ID pipeline register. It holds up to DEPTH fetched instructions with their addresses and fetch-fault flags. Both sides use a valid/ready handshake, which replaces the hold-level stall scheme. A flush input discards all entries on redirect, and the output presents a NOP bubble whenever the queue is empty.

## Interface
- INST_W, 32, instruction width in bits
- ADDR_W, 32, instruction address width in bits
- DEPTH, 4, number of entries; power of two, minimum 2
- NOP_INST, 32'h0000_0013, value driven on out_inst_o when the queue is empty
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; asynchronous, active-high
- flush_i  input  1  synchronous flush on pipeline redirect; discards all entries
- in_valid_i  input  1  fetch side presents an instruction
- in_ready_o  output  1  queue accepts an instruction this cycle
- in_inst_i  input  INST_W  fetched instruction
- in_addr_i  input  ADDR_W  address of the fetched instruction
- in_err_i  input  1  fetch fault (bus error or misaligned) for this instruction
- out_valid_o  output  1  head entry is valid
- out_ready_i  input  1  decoder consumes the head this cycle
- out_inst_o  output  INST_W  head instruction, or NOP_INST when empty
- out_addr_o  output  ADDR_W  head address, or 0 when empty
- out_err_o  output  1  head fault flag, or 0 when empty
- count_o  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH

## Operation
- **Storage.** Circular buffer of DEPTH entries, each holding {inst, addr, err}. Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- **Occupancy.** A count register is kept separately so that full and empty are unambiguous.
- **Push.** A push occurs when in_valid_i && in_ready_o && !flush_i. The entry is written at the write pointer, and the write pointer increments.
- **Pop.** A pop occurs when out_valid_o && out_ready_i && !flush_i. The read pointer increments.
- **Count update.** On a push without a pop, count increases by 1. On a pop without a push, count decreases by 1. On a simultaneous push and pop, count is unchanged.
- **in_ready_o.** Equals (count != DEPTH) and depends only on registered state. There is no combinational path from out_ready_i. When the queue is full, a push is refused even in a cycle that also pops.
- **out_valid_o.** Equals (count != 0). When the queue is empty:
  - out_inst_o = NOP_INST
  - out_addr_o = 0
  - out_err_o = 0
  - otherwise these outputs come straight from the entry at the read pointer.
- **No bypass.** An entry pushed in cycle N is visible at the output no earlier than cycle N+1.
- **Flush.** When flush_i = 1 at an edge:
  - count and both pointers are set to 0;
  - any push or pop in that same cycle is ignored, and the incoming instruction is dropped.
  - Flush has priority over everything except rst.
- **Entry contents.** Entries are not cleared by flush or reset. Only the pointers and count are.
- **Fault flags.** err is carried through unchanged. The queue takes no action on it; the decoder raises the exception.

## Timing
- **Reset (asynchronous, while rst = 1).**
  - count = 0 and pointers = 0.
  - Outputs: out_valid_o = 0, in_ready_o = 1, out_inst_o = NOP_INST, out_addr_o = 0, out_err_o = 0, count_o = 0.
- **Reset asserted mid-operation.** Contents are lost immediately. No handshake completes in the cycle rst is asserted.
- **Latency.** Push-to-output latency is 1 cycle.
- **Throughput.** One push and one pop per cycle when 0 < count < DEPTH.
- **Full (count = DEPTH).** in_ready_o = 0. A pop in this cycle makes in_ready_o = 1 in the next cycle.
- **Empty (count = 0).** out_valid_o = 0 and out_ready_i is ignored. A push in this cycle makes out_valid_o = 1 in the next cycle.
- **Wrap-around.** The pointer advances from DEPTH-1 to 0 with no effect on the data ordering.
- **Output stability.** While out_valid_o = 1 and out_ready_i = 0, all out_* signals hold their values, unless flush_i or rst occurs.
- **Input stability.** The fetch side is not required to hold its inputs when in_ready_o = 0; the queue samples them only on an accepted push.

## Test plan
- **Reset.** Assert rst mid-cycle with 3 entries queued. Required response, immediately: out_valid_o = 0, count_o = 0, out_inst_o = 0x00000013, in_ready_o = 1.
- **Fill, then drain.** With DEPTH = 4 and out_ready_i = 0, push addresses 0x100, 0x104, 0x108, 0x10C.
  - After the 4th push: count_o = 4 and in_ready_o = 0.
  - A 5th push of 0x110 is refused.
  - Then set out_ready_i = 1. Required: the 4 entries drain in order 0x100..0x10C, followed by out_valid_o = 0.
- **Full with simultaneous pop.** With the queue full, assert in_valid_i and out_ready_i in the same cycle. Required: the pop occurs, the push is refused, count_o = 3, and in_ready_o = 1 in the next cycle.
- **Streaming with wrap.** Push and pop every cycle for 10 consecutive instructions, starting with count = 1. Required:
  - count_o stays at 1 throughout;
  - outputs appear in order with exactly 1-cycle lag;
  - the pointers wrap at least twice.
- **Flush priority.** With count = 3, assert flush_i together with a push of 0x200 and a pop. Required, next cycle: count_o = 0, out_valid_o = 0, and 0x200 never appears at the output.
- **Fault propagation.** Push 0x300 with in_err_i = 1, then 0x304 with in_err_i = 0. Required: out_err_o = 1 while 0x300 is at the head, and out_err_o = 0 while 0x304 is at the head.
